// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module : sobel_pkg
// Shared constants, FSM state type and gradient helper for sobel_edge_core.
// Rev    : 1.0  initial release
// ============================================================================
package sobel_pkg;

    localparam int              IMG_W_DEF     = 100;
    localparam int              IMG_H_DEF     = 100;
    localparam int              GRAD_W        = 11;
    localparam logic [7:0]      EDGE_VAL_DEF  = 8'h00;
    localparam logic [7:0]      BG_VAL_DEF    = 8'hFF;
    localparam logic [GRAD_W-1:0] THRESHOLD_DEF = 11'd64;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_CALC = 1'b1
    } state_t;

    // Gradients span -1020..1020, so the negation never overflows GRAD_W bits.
    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buf.sv
`default_nettype none
// ============================================================================
// Module : sobel_line_buf
// Dual line buffer {row r-2, row r-1}, combinational read, write on enable.
// Rev    : 1.0  initial release
// ============================================================================
module sobel_line_buf #(
    parameter int DEPTH = 100,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/sobel_edge_core.sv
`default_nettype none
// ============================================================================
// Module : sobel_edge_core
// Streaming 3x3 Sobel edge detector, one binary byte per interior pixel.
// Rev    : 1.0  initial release
// ============================================================================
module sobel_edge_core
    import sobel_pkg::*;
#(
    parameter int                IMG_W     = IMG_W_DEF,
    parameter int                IMG_H     = IMG_H_DEF,
    parameter logic [GRAD_W-1:0] THRESHOLD = THRESHOLD_DEF,
    parameter logic [7:0]        EDGE_VAL  = EDGE_VAL_DEF,
    parameter logic [7:0]        BG_VAL    = BG_VAL_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    state_t        state_q, state_d;
    logic          col_wrap, row_last, pix_ok;

    logic [15:0]   lb_rd;
    logic [7:0]    p11_q, p12_q, p13_q, p21_q, p22_q, p23_q, p31_q, p32_q, p33_q;
    logic          valid1_q, valid2_q;
    logic [9:0]    gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [GRAD_W-1:0] sum;
    logic [7:0]    po_data_q;
    logic          po_flag_q, frame_done_q;

    sobel_line_buf #(.DEPTH(IMG_W)) u_line_buf (
        .sys_clk (sys_clk),
        .we_i    (pi_flag & ~sys_rst),
        .addr_i  (col_q),
        .wdata_i ({lb_rd[7:0], pi_data}),
        .rdata_o (lb_rd)
    );

    assign col_wrap = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign pix_ok   = pi_flag && (state_q == S_CALC) && (col_q >= CW'(2));

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (pi_flag) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        case (state_q)
            S_FILL:  if (pi_flag && col_wrap && (row_q == RW'(1))) state_d = S_CALC;
            S_CALC:  if (pi_flag && col_wrap && row_last)          state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // Window rows: p1x = row r-2, p2x = row r-1, p3x = row r; column 3 is newest.
    assign gx_pos = {2'b00, p13_q} + {1'b0, p23_q, 1'b0} + {2'b00, p33_q};
    assign gx_neg = {2'b00, p11_q} + {1'b0, p21_q, 1'b0} + {2'b00, p31_q};
    assign gy_pos = {2'b00, p11_q} + {1'b0, p12_q, 1'b0} + {2'b00, p13_q};
    assign gy_neg = {2'b00, p31_q} + {1'b0, p32_q, 1'b0} + {2'b00, p33_q};
    assign gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    assign gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    assign sum    = abs_grad(gx_q) + abs_grad(gy_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= S_FILL;
            {p11_q, p12_q, p13_q} <= '0;
            {p21_q, p22_q, p23_q} <= '0;
            {p31_q, p32_q, p33_q} <= '0;
            valid1_q     <= 1'b0;
            valid2_q     <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            po_data_q    <= 8'h00;
            po_flag_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            if (pi_flag) begin
                {p11_q, p12_q, p13_q} <= {p12_q, p13_q, lb_rd[15:8]};
                {p21_q, p22_q, p23_q} <= {p22_q, p23_q, lb_rd[7:0]};
                {p31_q, p32_q, p33_q} <= {p32_q, p33_q, pi_data};
            end
            valid1_q     <= pix_ok;
            valid2_q     <= valid1_q;
            if (valid1_q) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
            po_flag_q    <= valid2_q;
            if (valid2_q) begin
                po_data_q <= (sum >= THRESHOLD) ? EDGE_VAL : BG_VAL;
            end
            frame_done_q <= pi_flag && col_wrap && row_last;
        end
    end

    assign po_data    = po_data_q;
    assign po_flag    = po_flag_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_core.sv
`default_nettype none
// ============================================================================
// Module : tb_sobel_edge_core
// Scoreboard bench: random frames vs a direct Sobel reference on a stored image.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sobel_edge_core;

    localparam int W = 10;
    localparam int H = 7;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_done;

    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t       q[$];
    int         fdq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         fd_seen = 0;
    int         fd_exp = 0;
    logic [7:0] last_po = 8'h00;
    int         img[H][W];

    sobel_edge_core #(
        .IMG_W(W), .IMG_H(H), .THRESHOLD(11'd64), .EDGE_VAL(8'h00), .BG_VAL(8'hFF)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pi_data    (pi_data),
        .pi_flag    (pi_flag),
        .po_data    (po_data),
        .po_flag    (po_flag),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(int r, int c);
        int gx, gy, s;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
           - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (s >= 64) ? 8'h00 : 8'hFF;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic fill(int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0:       img[r][c] = 8'h80;
                    1:       img[r][c] = (c < W/2) ? 0 : 255;
                    2:       img[r][c] = (c < W/2) ? 0 : 16;
                    3:       img[r][c] = (c < W/2) ? 0 : 15;
                    5:       img[r][c] = (r < H/2) ? 30 : 200;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic drive_pixel(int r, int c, int gap);
        pi_data = 8'(img[r][c]);
        pi_flag = 1'b1;
        if (r >= 2 && c >= 2) q.push_back('{model(r, c), cyc + 3});
        if (r == H-1 && c == W-1) fdq.push_back(cyc + 1);
        @(posedge sys_clk); #1;
        if (gap > 0) begin
            pi_flag = 1'b0;
            repeat (gap) begin
                @(posedge sys_clk); #1;
            end
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        pi_flag = 1'b1;
        pi_data = 8'($urandom);
        @(posedge sys_clk);
        q.delete();
        fdq.delete();
        last_po = 8'h00;
        #1;
        sys_rst = 1'b0;
        pi_flag = 1'b0;
        check("reset_po_flag", 32'(po_flag), 32'd0);
        check("reset_po_data", 32'(po_data), 32'h00);
        check("reset_frame_done", 32'(frame_done), 32'd0);
    endtask

    task automatic send_frame(int gap_mode, int abort_at);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pixel(r, c, (gap_mode < 0) ? int'($urandom_range(0, 6)) : gap_mode);
                if (r*W + c == abort_at) begin
                    do_reset();
                    return;
                end
            end
        end
        pi_flag = 1'b0;
        fd_exp++;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].t < cyc) begin
            e = q.pop_front();
            total++; bad++;
            $display("FAIL missing_po_flag: got none required data=%h at cyc %0d", e.data, e.t);
        end
        while (fdq.size() > 0 && fdq[0] < cyc) begin
            total++; bad++;
            $display("FAIL missing_frame_done: got none required pulse at cyc %0d", fdq.pop_front());
        end
        if (po_flag) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_po_flag: got data=%h at cyc %0d required no output", po_data, cyc);
            end else begin
                e = q.pop_front();
                if (po_data !== e.data || cyc != e.t) begin
                    bad++;
                    $display("FAIL po_data: got %h at cyc %0d required %h at cyc %0d",
                             po_data, cyc, e.data, e.t);
                end
            end
            last_po = po_data;
        end else begin
            total++;
            if (po_data !== last_po) begin
                bad++;
                $display("FAIL po_hold: got %h required %h", po_data, last_po);
            end
        end
        if (frame_done) begin
            fd_seen++;
            total++;
            if (fdq.size() == 0 || fdq[0] != cyc) begin
                bad++;
                $display("FAIL frame_done: got pulse at cyc %0d required %0d", cyc,
                         (fdq.size() == 0) ? -1 : fdq[0]);
            end
            if (fdq.size() > 0) void'(fdq.pop_front());
        end
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        do_reset();
        fill(0); send_frame(5, -1);        // flat, widely spaced
        fill(1); send_frame(-1, -1);       // full-height vertical step
        fill(2); send_frame(0, -1);        // step of 16: exactly at threshold
        fill(3); send_frame(0, -1);        // step of 15: just below threshold
        fill(4); send_frame(0, -1);        // random, back-to-back
        send_frame(37, -1);                // same image, sparse pixels
        fill(5); send_frame(-1, -1);       // horizontal step
        fill(4); send_frame(0, 35);        // aborted mid-frame by reset
        fill(4); send_frame(-1, -1);
        fill(1); send_frame(0, -1);        // step then flat back-to-back
        fill(0); send_frame(0, -1);
        repeat (10) @(posedge sys_clk);
        #1;
        check("drain_po_queue", 32'(q.size()), 32'd0);
        check("drain_fd_queue", 32'(fdq.size()), 32'd0);
        check("frame_done_count", 32'(fd_seen), 32'(fd_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
